// File: rtl/hcp_gmii_write.sv
// GMII receive framer: strips preamble/SFD and writes 9-bit FIFO entries (bit 8 = first/last delimiter).
// Optional build macro HCP_GMII_RX_ER_DROP_EN: rx_er truncates (or drops) the frame in progress.
module hcp_gmii_write #(
    parameter int MAX_FRAME_LEN = 2047
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_gmii_rx_dv,
    input  logic [7:0] iv_gmii_rxd,
    input  logic       i_gmii_rx_er,
    output logic [8:0] ov_data,
    output logic       o_data_wr,
    input  logic       i_fifo_full,
    input  logic       i_fifo_almostfull,
    output logic       o_frame_drop_pulse,
    output logic       o_fifo_overflow_pulse,
    output logic       o_oversize_pulse,
    output logic       o_rx_err_pulse
);

    localparam int CW = $clog2(MAX_FRAME_LEN + 1);
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_FRAME_LEN);

`ifdef HCP_GMII_RX_ER_DROP_EN
    localparam bit RX_ER_EN = 1'b1;
`else
    localparam bit RX_ER_EN = 1'b0;
`endif

    typedef enum logic [2:0] {
        IDLE_S,
        PREAMBLE_S,
        FIRST_S,
        TRANS_S,
        FULL_WAIT_S,
        DISCARD_S
    } state_t;

    state_t          state_q;
    logic            dv_q;
    logic            er_q;
    logic [7:0]      rxd_q;
    logic [7:0]      hold_q;
    logic            first_q;
    logic [CW-1:0]   cnt_q;
    logic [CW-1:0]   cnt_d;
    logic            er_hit;

    assign cnt_d  = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
    assign er_hit = RX_ER_EN && er_q;

    // The GMII bus is registered once; the FSM works on the registered copy,
    // so a byte is written two edges after it was sampled.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q               <= IDLE_S;
            dv_q                  <= 1'b0;
            er_q                  <= 1'b0;
            rxd_q                 <= 8'h00;
            hold_q                <= 8'h00;
            first_q               <= 1'b0;
            cnt_q                 <= '0;
            ov_data               <= 9'h000;
            o_data_wr             <= 1'b0;
            o_frame_drop_pulse    <= 1'b0;
            o_fifo_overflow_pulse <= 1'b0;
            o_oversize_pulse      <= 1'b0;
            o_rx_err_pulse        <= 1'b0;
        end else begin
            dv_q                  <= i_gmii_rx_dv;
            er_q                  <= i_gmii_rx_er;
            rxd_q                 <= iv_gmii_rxd;
            o_data_wr             <= 1'b0;
            o_frame_drop_pulse    <= 1'b0;
            o_fifo_overflow_pulse <= 1'b0;
            o_oversize_pulse      <= 1'b0;
            o_rx_err_pulse        <= 1'b0;
            case (state_q)
                IDLE_S: begin
                    if (dv_q) state_q <= PREAMBLE_S;
                end
                PREAMBLE_S: begin
                    if (!dv_q) begin
                        state_q <= IDLE_S;
                    end else if (rxd_q == 8'hD5) begin
                        if (i_fifo_almostfull) begin
                            o_frame_drop_pulse <= 1'b1;
                            state_q            <= DISCARD_S;
                        end else begin
                            cnt_q   <= '0;
                            state_q <= FIRST_S;
                        end
                    end
                end
                FIRST_S: begin
                    if (!dv_q) begin
                        state_q <= IDLE_S;
                    end else if (er_hit) begin
                        o_frame_drop_pulse <= 1'b1;
                        state_q            <= DISCARD_S;
                    end else begin
                        hold_q  <= rxd_q;
                        first_q <= 1'b1;
                        cnt_q   <= CW'(1);
                        state_q <= TRANS_S;
                    end
                end
                TRANS_S: begin
                    // A lone first byte can never form a delimited frame, so it is dropped.
                    if (!dv_q && first_q) begin
                        o_frame_drop_pulse <= 1'b1;
                        state_q            <= IDLE_S;
                    end else if (i_fifo_full) begin
                        state_q <= FULL_WAIT_S;
                    end else if (!dv_q) begin
                        o_data_wr <= 1'b1;
                        ov_data   <= {1'b1, hold_q};
                        state_q   <= IDLE_S;
                    end else if (er_hit || cnt_q == MAX_CNT) begin
                        if (first_q) begin
                            o_frame_drop_pulse <= 1'b1;
                        end else begin
                            o_data_wr        <= 1'b1;
                            ov_data          <= {1'b1, hold_q};
                            o_rx_err_pulse   <= er_hit;
                            o_oversize_pulse <= !er_hit;
                        end
                        state_q <= DISCARD_S;
                    end else begin
                        o_data_wr <= 1'b1;
                        ov_data   <= {first_q, hold_q};
                        hold_q    <= rxd_q;
                        first_q   <= 1'b0;
                        cnt_q     <= cnt_d;
                    end
                end
                FULL_WAIT_S: begin
                    if (!i_fifo_full) begin
                        if (first_q) begin
                            o_frame_drop_pulse <= 1'b1;
                        end else begin
                            o_data_wr             <= 1'b1;
                            ov_data               <= {1'b1, hold_q};
                            o_fifo_overflow_pulse <= 1'b1;
                        end
                        state_q <= dv_q ? DISCARD_S : IDLE_S;
                    end
                end
                DISCARD_S: begin
                    if (!dv_q) state_q <= IDLE_S;
                end
                default: state_q <= IDLE_S;
            endcase
        end
    end

endmodule

// File: tb/tb_hcp_gmii_write.sv
// Bench for hcp_gmii_write: directed and random GMII frames checked against a frame-level model.
module tb_hcp_gmii_write;

    localparam int MAXL = 64;
`ifdef HCP_GMII_RX_ER_DROP_EN
    localparam bit ER_EN = 1'b1;
`else
    localparam bit ER_EN = 1'b0;
`endif

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       dv    = 1'b0;
    logic       er    = 1'b0;
    logic       full  = 1'b0;
    logic       af    = 1'b0;
    logic [7:0] rxd   = 8'h00;
    logic [8:0] ov_data;
    logic       data_wr, drop_p, ovf_p, ovs_p, err_p;

    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;
    logic full_s = 1'b0;
    logic [8:0] exp_q[$];
    logic [8:0] got_q[$];
    logic [7:0] pay[$];
    int exp_drop = 0, exp_ovf = 0, exp_ovs = 0, exp_err = 0;
    int got_drop = 0, got_ovf = 0, got_ovs = 0, got_err = 0;
    int first_wr_cyc = -1;
    int drive_cyc = 0;

    always #4 clk = ~clk;

    hcp_gmii_write #(.MAX_FRAME_LEN(MAXL)) dut (
        .i_clk                 (clk),
        .i_rst_n               (rst_n),
        .i_gmii_rx_dv          (dv),
        .iv_gmii_rxd           (rxd),
        .i_gmii_rx_er          (er),
        .ov_data               (ov_data),
        .o_data_wr             (data_wr),
        .i_fifo_full           (full),
        .i_fifo_almostfull     (af),
        .o_frame_drop_pulse    (drop_p),
        .o_fifo_overflow_pulse (ovf_p),
        .o_oversize_pulse      (ovs_p),
        .o_rx_err_pulse        (err_p)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
        full_s = full;
    end

    // Output monitor, sampled on the falling edge.
    initial forever begin
        @(negedge clk);
        if (rst_n) begin
            if (full_s) check("no_write_while_full", 32'(data_wr), 32'd0);
            if (data_wr) begin
                if (first_wr_cyc < 0) first_wr_cyc = cyc;
                got_q.push_back(ov_data);
            end
            got_drop += int'(drop_p);
            got_ovf  += int'(ovf_p);
            got_ovs  += int'(ovs_p);
            got_err  += int'(err_p);
        end
    end

    // Frame-level expectation: the earliest truncating event (by arriving byte
    // position, ties full > rx_er > length) ends the frame on the byte before it.
    task automatic model(input bit af_i, input int k, input int e);
        int n;
        int p;
        int kind;
        int t;
        n = pay.size();
        p = 0;
        kind = 0;
        if (af_i) begin
            exp_drop++;
            return;
        end
        if (k > 0) begin p = k - 1; kind = 1; end
        if (ER_EN && e > 0 && (p == 0 || e < p)) begin p = e; kind = 2; end
        if (n > MAXL && (p == 0 || MAXL + 1 < p)) begin p = MAXL + 1; kind = 3; end
        t = (p > 0) ? p - 1 : n;
        if (t == 0) begin
            if (p > 0) exp_drop++;
            return;
        end
        if (t == 1) begin
            exp_drop++;
            return;
        end
        for (int i = 0; i < t; i++) exp_q.push_back({(i == 0 || i == t - 1), pay[i]});
        case (kind)
            1: exp_ovf++;
            2: exp_err++;
            3: exp_ovs++;
            default: ;
        endcase
    endtask

    task automatic fill_ramp(input int n);
        pay.delete();
        for (int i = 0; i < n; i++) pay.push_back(8'(i));
    endtask

    task automatic fill_rand(input int n);
        pay.delete();
        for (int i = 0; i < n; i++) pay.push_back(8'($urandom));
    endtask

    // k: byte index (1-based) driven together with the first of 5 full cycles; e: byte carrying rx_er.
    task automatic send_frame(input bit af_i, input int k, input int e, input int gap);
        int n;
        n = pay.size();
        model(af_i, k, e);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            dv = 1'b1; af = af_i; er = 1'b0; full = 1'b0;
            rxd = (i == 7) ? 8'hD5 : 8'h55;
        end
        for (int i = 1; i <= n; i++) begin
            @(negedge clk);
            if (i == 1) drive_cyc = cyc;
            rxd  = pay[i-1];
            er   = (i == e);
            full = (k > 0 && i >= k && i < k + 5);
        end
        for (int i = 0; i < gap; i++) begin
            @(negedge clk);
            dv = 1'b0; rxd = 8'h00; er = 1'b0; full = 1'b0; af = 1'b0;
        end
    endtask

    task automatic check_batch(input string tag);
        int ne;
        int ng;
        repeat (15) @(negedge clk);
        ne = exp_q.size();
        ng = got_q.size();
        check({tag, "_count"}, 32'(ng), 32'(ne));
        for (int i = 0; i < ne && i < ng; i++) check({tag, "_data"}, 32'(got_q[i]), 32'(exp_q[i]));
        check({tag, "_drop"}, 32'(got_drop), 32'(exp_drop));
        check({tag, "_ovf"},  32'(got_ovf),  32'(exp_ovf));
        check({tag, "_ovs"},  32'(got_ovs),  32'(exp_ovs));
        check({tag, "_err"},  32'(got_err),  32'(exp_err));
        $display("batch %s: %0d writes expected, %0d observed", tag, ne, ng);
        exp_q.delete(); got_q.delete();
        exp_drop = 0; exp_ovf = 0; exp_ovs = 0; exp_err = 0;
        got_drop = 0; got_ovf = 0; got_ovs = 0; got_err = 0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        int sel;
        int k;
        int e;
        bit a;

        repeat (3) @(negedge clk);
        check("rst_data",  32'(ov_data), 32'd0);
        check("rst_wr",    32'(data_wr), 32'd0);
        check("rst_drop",  32'(drop_p),  32'd0);
        check("rst_ovf",   32'(ovf_p),   32'd0);
        check("rst_ovs",   32'(ovs_p),   32'd0);
        check("rst_err",   32'(err_p),   32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        first_wr_cyc = -1;
        fill_ramp(64);
        send_frame(1'b0, 0, 0, 4);
        check_batch("ramp64");
        check("latency", 32'(first_wr_cyc), 32'(drive_cyc + 3));

        fill_rand(100);
        send_frame(1'b1, 0, 0, 4);
        check_batch("almostfull");

        fill_rand(30);
        send_frame(1'b0, 12, 0, 3);
        fill_rand(20);
        send_frame(1'b0, 0, 0, 3);
        check_batch("full_stall");

        fill_rand(100);
        send_frame(1'b0, 0, 0, 3);
        check_batch("oversize");

        fill_rand(1);
        send_frame(1'b0, 0, 0, 3);
        pay.delete(); pay.push_back(8'hAA); pay.push_back(8'hBB);
        send_frame(1'b0, 0, 0, 3);
        pay.delete();
        send_frame(1'b0, 0, 0, 3);
        check_batch("short");

        fill_rand(40);
        send_frame(1'b0, 0, 20, 3);
        check_batch("rx_er");

        fill_rand(20);
        send_frame(1'b0, 3, 0, 3);
        check_batch("full_first");

        for (int i = 0; i < 3; i++) begin
            fill_rand(int'($urandom_range(2, 30)));
            send_frame(1'b0, 0, 0, 1);
        end
        check_batch("ifg1");

        for (int b = 0; b < 10; b++) begin
            for (int f = 0; f < 4; f++) begin
                n = int'($urandom_range(0, 100));
                sel = int'($urandom_range(0, 5));
                a = 1'b0; k = 0; e = 0;
                fill_rand(n);
                if (sel == 1 && n >= 1) a = 1'b1;
                else if (sel == 2 && n >= 9) k = int'($urandom_range(3, n - 6));
                else if (sel == 3 && n >= 1) e = int'($urandom_range(1, n));
                send_frame(a, k, e, int'($urandom_range(1, 4)));
            end
            check_batch("rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/hcp_gmii_write.md
# hcp_gmii_write

Receive-side GMII framer feeding the HCP interface-input FIFO. Samples the GMII receive bus, strips preamble/SFD, and writes each frame as 9-bit entries whose bit 8 flags the first and last byte. It guards against FIFO overflow, oversize frames and runt frames so the downstream FIFO reader always sees well-formed start/end-delimited frames. Sits in the GMII receive clock domain, directly upstream of the async FIFO whose read side drains the frames.

## Interface
- MAX_FRAME_LEN, 2047: maximum data bytes (after SFD) written per frame; longer frames are truncated.
- i_clk  in  1  GMII receive clock (125 MHz).
- i_rst_n  in  1  asynchronous, active-low reset.
- i_gmii_rx_dv  in  1  GMII receive data valid.
- iv_gmii_rxd  in  8  GMII receive data.
- i_gmii_rx_er  in  1  GMII receive error.
- ov_data  out  9  FIFO write data; bit 8 = frame delimiter (first or last byte), [7:0] = byte.
- o_data_wr  out  1  FIFO write strike, one entry per cycle.
- i_fifo_full  in  1  FIFO full; never write while high.
- i_fifo_almostfull  in  1  FIFO cannot hold one MAX_FRAME_LEN frame.
- o_frame_drop_pulse  out  1  1-cycle pulse: frame dropped at SFD (almostfull) or runt.
- o_fifo_overflow_pulse  out  1  1-cycle pulse: frame truncated by i_fifo_full.
- o_oversize_pulse  out  1  1-cycle pulse: frame truncated at MAX_FRAME_LEN.
- o_rx_err_pulse  out  1  1-cycle pulse: frame truncated by rx_er (see Configuration).

## Operation
- Reset: all outputs 0, state IDLE_S, hold register, byte counter and flags cleared.
- One-byte hold register: each byte is written only once the next byte (or dv low) is seen, so the last byte can carry bit 8.
- States:
  - IDLE_S: wait for dv=1 -> PREAMBLE_S.
  - PREAMBLE_S: dv=0 -> IDLE_S; rxd=0xD5 -> if almostfull then pulse drop, DISCARD_S; else FIRST_S, counter=0.
  - FIRST_S: dv=0 -> no byte, IDLE_S (empty frame, no pulse); else load hold, mark hold as first, counter=1 -> TRANS_S.
  - TRANS_S: dv=1 -> write hold (bit 8 = first flag), load new byte, counter+1; dv=0 -> write hold with bit 8=1 -> IDLE_S. A frame of only 1 data byte (dv falls with first flag still set) is not written; pulse drop -> IDLE_S.
  - Truncation in TRANS_S (priority: full, then rx_er, then length): write hold with bit 8=1, pulse corresponding flag, -> DISCARD_S. When counter reaches MAX_FRAME_LEN and dv still 1, the held byte ends the frame.
  - FULL_WAIT_S: entered when i_fifo_full=1 while a write is due; no write; when full drops write hold with bit 8=1, pulse overflow, -> DISCARD_S (or IDLE_S if dv already 0). If hold is still the first byte, it is dropped instead (pulse drop, no overflow).
  - DISCARD_S: no writes until dv=0 -> IDLE_S.
- Counter 11 bits, saturating; never wraps.
- Simultaneous events: dv falling in the same cycle as full asserting -> FULL_WAIT_S path, final byte still flagged; only one pulse per frame.
- Reset mid-frame: state and hold are cleared immediately; the partially written frame is left unterminated and the downstream reader is expected to recover.

## Timing
- Byte sampled at edge k appears on ov_data/o_data_wr after edge k+2 when no stall occurs.
- Last byte: dv low sampled at edge k+1, written after edge k+2 with bit 8=1.
- o_data_wr is never high while i_fifo_full is sampled high in the same cycle.
- Pulses are asserted in the same cycle as the terminating write, or in the cycle of the drop decision.
- Minimum back-to-back IFG of 1 cycle is handled; IDLE_S is re-entered on dv=0.

## Configuration
- HCP_GMII_RX_ER_DROP_EN defined: i_gmii_rx_er=1 with dv=1 in TRANS_S truncates the frame (flagged end byte, o_rx_err_pulse), then DISCARD_S; in FIRST_S it drops the frame.
- Undefined: rx_er is ignored; o_rx_err_pulse is tied 0.

## Test plan
- 7×0x55, 0xD5, 64 bytes 0x00..0x3F -> 64 writes; first 0x100, last 0x13F, others bit 8=0; byte 0x00 written 2 cycles after sampling.
- almostfull=1 at SFD, 100-byte frame -> no writes, one o_frame_drop_pulse.
- i_fifo_full held high 5 cycles after byte 10 -> no write while full; byte 10 written with bit 8=1, o_fifo_overflow_pulse, remainder discarded, next frame accepted normally.
- MAX_FRAME_LEN=16, 40-byte frame -> 16 writes, 16th has bit 8=1, o_oversize_pulse=1.
- Frame with 1 data byte after SFD -> no writes, o_frame_drop_pulse; frame with 2 bytes 0xAA,0xBB -> 0x1AA, 0x1BB.
- With HCP_GMII_RX_ER_DROP_EN, rx_er at byte 20 -> byte 19 written with bit 8=1, o_rx_err_pulse; without the macro, full frame written unchanged.
